// File: rtl/seq_pkg.sv
// Shared types and helpers for the address sequencer.
package seq_pkg;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int ADDR_W = 4;

    // One step of the index in the requested direction, natural 4-bit wrap.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic d);
        return (d == DIR_DOWN) ? a - ADDR_W'(1) : a + ADDR_W'(1);
    endfunction

    // True when the step from a in direction d crosses the 15/0 boundary.
    function automatic logic wraps(input logic [ADDR_W-1:0] a, input logic d);
        return (d == DIR_DOWN) ? (a == '0) : (a == {ADDR_W{1'b1}});
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser, stability debounce and registered rising-edge pulse.
module btn_debounce #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   level_d;
    logic                   raw_s;

    assign raw_s = sync_q[SYNC_STAGES-1];

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(raw);
    end

    // Accept a new level only after it has disagreed with the old one for DB_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (raw_s != level) begin
            if (cnt == CNT_LAST) begin
                level <= raw_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered 0->1 detect on the accepted level; release produces nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// Index sequencer: free-running prescaled advance or button single-step, with direction and clear.
module addr_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              dir,
    input  logic              step_btn,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic              adv,
    output logic              wrap
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Switch synchronisers, one row per input.
    localparam int S_RUN = 0;
    localparam int S_DIR = 1;
    localparam int S_CLR = 2;

    logic [2:0][SYNC_STAGES-1:0] sw_q;
    logic                        run_s, dir_s, clr_s;

    state_t                      state_q, state_d;
    logic [PRE_W-1:0]            pre_q;
    logic                        count_en, tick, advance;
    logic                        step_level, step_rise, step_pulse;

    assign run_s = sw_q[S_RUN][SYNC_STAGES-1];
    assign dir_s = sw_q[S_DIR][SYNC_STAGES-1];
    assign clr_s = sw_q[S_CLR][SYNC_STAGES-1];

    // Shift the raw switches through their synchroniser chains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q <= '0;
        end else begin
            sw_q[S_RUN] <= (sw_q[S_RUN] << 1) | SYNC_STAGES'(run);
            sw_q[S_DIR] <= (sw_q[S_DIR] << 1) | SYNC_STAGES'(dir);
            sw_q[S_CLR] <= (sw_q[S_CLR] << 1) | SYNC_STAGES'(clr);
        end
    end

    btn_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .level (step_level),
        .rise  (step_rise)
    );

    // A step only counts while the accepted level is still high.
    assign step_pulse = step_rise & step_level;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PAUSED;
        else     state_q <= state_d;
    end

    // FSM next state follows the synced run switch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSED:  if (run_s)  state_d = RUNNING;
            RUNNING: if (!run_s) state_d = PAUSED;
            default: state_d = PAUSED;
        endcase
    end

    // FSM outputs: prescaler enable and the advance request. Counting only while
    // RUNNING in both this and the next cycle keeps the prescaler at 0 in PAUSED
    // and makes every re-entry start a full period.
    always_comb begin
        count_en = (state_q == RUNNING) && (state_d == RUNNING);
        tick     = (state_q == RUNNING) && (pre_q == PRE_LAST);
        advance  = tick | ((state_q == PAUSED) && step_pulse);
    end

    // Prescaler: 0..TICK_DIV-1 while running, cleared by clr or when not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             pre_q <= '0;
        else if (clr_s || !count_en)         pre_q <= '0;
        else if (pre_q == PRE_LAST)          pre_q <= '0;
        else                                 pre_q <= pre_q + PRE_W'(1);
    end

    // Address register with coincident adv/wrap pulses; clear drops any pending advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            adv  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            adv  <= 1'b0;
            wrap <= 1'b0;
            if (clr_s) begin
                addr <= '0;
            end else if (advance) begin
                addr <= next_addr(addr, dir_s);
                adv  <= 1'b1;
                wrap <= wraps(addr, dir_s);
            end
        end
    end

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: directed scenarios plus a randomized run against a behavioural model.
module tb_addr_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int DB_CYCLES   = 3;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       step_btn = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] addr;
    logic       adv;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addr_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .dir      (dir),
        .step_btn (step_btn),
        .clr      (clr),
        .addr     (addr),
        .adv      (adv),
        .wrap     (wrap)
    );

    // Behavioural model: inputs seen SYNC_STAGES edges late, a stable-run counter
    // for the button, and a two-edge delay from acceptance to usable step pulse.
    typedef struct packed {
        logic [1:0] rs, ds, cs, bs;
        logic       running;
        int         pre;
        int         addr;
        logic       adv, wrap;
        logic       lvl;
        int         dbn;
        logic [1:0] rdly;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t c, logic r, logic d, logic cl, logic b);
        mstate_t n;
        logic    go, acc;
        n      = c;
        acc    = 1'b0;
        n.rs   = {c.rs[0], r};
        n.ds   = {c.ds[0], d};
        n.cs   = {c.cs[0], cl};
        n.bs   = {c.bs[0], b};
        n.adv  = 1'b0;
        n.wrap = 1'b0;
        go     = c.running ? (c.pre == TICK_DIV - 1) : c.rdly[1];
        if (c.cs[1]) begin
            n.addr = 0;
            n.pre  = 0;
        end else begin
            if (go) begin
                n.adv = 1'b1;
                if (c.ds[1]) begin
                    n.wrap = (c.addr == 0);
                    n.addr = (c.addr + 15) % 16;
                end else begin
                    n.wrap = (c.addr == 15);
                    n.addr = (c.addr + 1) % 16;
                end
            end
            n.pre = (c.running && c.rs[1]) ? (c.pre + 1) % TICK_DIV : 0;
        end
        n.running = c.rs[1];
        if (c.bs[1] != c.lvl) begin
            if (c.dbn + 1 == DB_CYCLES) begin
                n.lvl = c.bs[1];
                n.dbn = 0;
                acc   = c.bs[1];
            end else begin
                n.dbn = c.dbn + 1;
            end
        end else begin
            n.dbn = 0;
        end
        n.rdly = {c.rdly[0], acc};
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_next(m, run, dir, clr, step_btn);
    end

    task automatic cyc;
        @(negedge clk);
    endtask

    // Hold the button for 'hold' cycles, release, and count advances over the whole episode.
    task automatic press(input int hold, output int nadv);
        nadv = 0;
        step_btn = 1'b1;
        repeat (hold) begin cyc(); if (adv) nadv++; end
        step_btn = 1'b0;
        repeat (14) begin cyc(); if (adv) nadv++; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) cyc();
        total++; if (addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", addr); end
        total++; if (adv !== 1'b0)  begin bad++; $display("FAIL reset_adv: got %b want 0", adv); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_run_up;
        int n = 0, last = -1, exp_a = 0;
        run = 1'b1;
        dir = 1'b0;
        for (int t = 0; t < 120 && n < 16; t++) begin
            cyc();
            if (adv) begin
                exp_a = (exp_a + 1) % 16;
                total++;
                if (addr !== 4'(exp_a) || wrap !== (exp_a == 0)) begin
                    bad++; $display("FAIL run_up_step: got addr=%0d wrap=%b want addr=%0d wrap=%b", addr, wrap, exp_a, exp_a == 0);
                end
                if (last >= 0) begin
                    total++;
                    if (t - last != TICK_DIV) begin bad++; $display("FAIL run_up_period: got %0d want %0d", t - last, TICK_DIV); end
                end
                last = t;
                n++;
            end else if (wrap) begin
                total++; bad++; $display("FAIL run_up_stray_wrap: got wrap=1 want 0 without adv");
            end
        end
        total++; if (n != 16) begin bad++; $display("FAIL run_up_count: got %0d want 16", n); end
    endtask

    task automatic test_dir_change;
        int n = 0;
        int exp_a[2] = '{0, 15};
        int exp_t[2] = '{4, 8};
        for (int t = 0; t < 12; t++) begin cyc(); if (adv) break; end
        total++; if (!(adv && addr === 4'd1)) begin bad++; $display("FAIL dir_start: got adv=%b addr=%0d want adv=1 addr=1", adv, addr); end
        dir = 1'b1;
        for (int t = 1; t <= 20 && n < 2; t++) begin
            cyc();
            if (adv) begin
                total++;
                if (addr !== 4'(exp_a[n]) || wrap !== (n == 1) || t != exp_t[n]) begin
                    bad++; $display("FAIL dir_down_%0d: got addr=%0d wrap=%b t=%0d want addr=%0d wrap=%b t=%0d",
                                    n, addr, wrap, t, exp_a[n], n == 1, exp_t[n]);
                end
                n++;
            end
        end
        total++; if (n != 2) begin bad++; $display("FAIL dir_count: got %0d want 2", n); end
    endtask

    task automatic test_pause_resume;
        int early = 0, first = -1;
        run = 1'b0;
        repeat (5) begin cyc(); if (adv) early++; end
        total++; if (early != 0) begin bad++; $display("FAIL pause_adv: got %0d want 0", early); end
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (adv) begin first = k; break; end
        end
        total++; if (first != SYNC_STAGES + 1 + TICK_DIV) begin bad++; $display("FAIL resume_latency: got %0d want %0d", first, SYNC_STAGES + 1 + TICK_DIV); end
        total++; if (addr !== 4'd14) begin bad++; $display("FAIL resume_addr: got %0d want 14", addr); end
    endtask

    task automatic test_step;
        int n;
        run = 1'b0;
        dir = 1'b0;
        clr = 1'b1;
        repeat (3) cyc();
        clr = 1'b0;
        repeat (4) cyc();
        total++; if (addr !== 4'd0) begin bad++; $display("FAIL step_clr: got %0d want 0", addr); end
        for (int i = 0; i < 5; i++) begin
            press(6, n);
            total++; if (n != 1) begin bad++; $display("FAIL step_pre_%0d: got %0d advances want 1", i, n); end
        end
        total++; if (addr !== 4'd5) begin bad++; $display("FAIL step_at5: got %0d want 5", addr); end
        press(6, n);
        total++; if (n != 1 || addr !== 4'd6) begin bad++; $display("FAIL step_hold6: got n=%0d addr=%0d want n=1 addr=6", n, addr); end
        press(2, n);
        total++; if (n != 0 || addr !== 4'd6) begin bad++; $display("FAIL step_glitch: got n=%0d addr=%0d want n=0 addr=6", n, addr); end
        press(10, n);
        total++; if (n != 1 || addr !== 4'd7) begin bad++; $display("FAIL step_hold10: got n=%0d addr=%0d want n=1 addr=7", n, addr); end
    endtask

    task automatic test_clr_terminal;
        int stray = 0;
        run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            if (k == 4) clr = 1'b1;
            if (k == 5) clr = 1'b0;
            if (k <= 6 && (adv || addr !== 4'd7)) stray++;
            if (k == 7) begin
                total++;
                if (addr !== 4'd0 || adv !== 1'b0 || wrap !== 1'b0) begin
                    bad++; $display("FAIL clr_wins: got addr=%0d adv=%b wrap=%b want 0 0 0", addr, adv, wrap);
                end
            end
            if (k >= 8 && k <= 10 && adv) stray++;
            if (k == 11) begin
                total++;
                if (adv !== 1'b1 || addr !== 4'd1) begin bad++; $display("FAIL clr_restart: got adv=%b addr=%0d want 1 1", adv, addr); end
            end
        end
        total++; if (stray != 0) begin bad++; $display("FAIL clr_window: got %0d stray events want 0", stray); end
    endtask

    task automatic test_async_reset;
        int quiet = 0;
        for (int t = 0; t < 60; t++) begin cyc(); if (adv && addr === 4'd9) break; end
        total++; if (addr !== 4'd9) begin bad++; $display("FAIL areset_setup: got %0d want 9", addr); end
        cyc();
        #2;
        rst = 1'b1;
        run = 1'b0;
        #1;
        total++;
        if (addr !== 4'd0 || adv !== 1'b0 || wrap !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: got addr=%0d adv=%b wrap=%b want 0 0 0", addr, adv, wrap);
        end
        cyc();
        rst = 1'b0;
        repeat (12) begin cyc(); if (adv || addr !== 4'd0) quiet++; end
        total++; if (quiet != 0) begin bad++; $display("FAIL areset_paused: got %0d events want 0", quiet); end
    endtask

    task automatic test_random;
        int shown = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            total++;
            if (addr !== 4'(m.addr) || adv !== m.adv || wrap !== m.wrap) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_%0d: got addr=%0d adv=%b wrap=%b want addr=%0d adv=%b wrap=%b",
                             i, addr, adv, wrap, m.addr, m.adv, m.wrap);
                end
            end
            if ($urandom_range(39) == 0) run = ~run;
            if ($urandom_range(24) == 0) dir = ~dir;
            clr = clr ? 1'($urandom_range(1)) : ($urandom_range(59) == 0);
            if ($urandom_range(7) == 0) step_btn = ~step_btn;
        end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_dir_change();
        test_pause_resume();
        test_step();
        test_clr_terminal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
